// File: rtl/sbr_drain_walker.sv
// sbr_drain_walker: sequential consumer of the SBR table.
//
// After start it repeatedly picks the critical bank, which is the SBR entry with the most
// requests, as reported by the table's combinational max search. It reads that entry and walks
// the entry's SRR chain from head to tail. Each SRR entry becomes one row command on a
// valid/ready issue port. Once the chain ends, the entry is retired by writing a zero request
// count, and the walk starts over. The drain finishes when the max search reports zero requests.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               begin a drain (sampled in IDLE only) / abandon it from any state
//   busy, done, err            status; done is a 1-cycle pulse; err is sticky, cleared on start
//   banks_drained              entries retired in the current drain (wraps)
//   sbr_find_max_en            enables the table max search
//   sbr_max_addr/_requests     max search result
//   sbr_rd_addr, sbr_rd_*      SBR read port (registered data, 1-cycle latency)
//   sbr_upd_*                  SBR retire write
//   srr_rd_addr, srr_rd_*      SRR read port (registered data, 1-cycle latency)
//   iss_*                      row command issue handshake and fields
//
// Optional feature: define SBR_WALK_GUARD_EN to build the chain-length guard. The guard adds a
// rows_left counter, ends a chain early when the row count runs out, and flags disagreements
// between the row count and the chain's last marker on err. Without the guard, err is tied to 0.

`ifndef MAX_SBR_ENTRIES
`define MAX_SBR_ENTRIES 16
`endif
`ifndef SBR_ID_WIDTH
`define SBR_ID_WIDTH 4
`endif
`ifndef REQUEST_ID_WIDTH
`define REQUEST_ID_WIDTH 8
`endif
`ifndef SRR_ID_WIDTH
`define SRR_ID_WIDTH 6
`endif
`ifndef ROW_WIDTH
`define ROW_WIDTH 16
`endif
`ifndef BANK_GROUP_WIDTH
`define BANK_GROUP_WIDTH 2
`endif
`ifndef BANK_WIDTH
`define BANK_WIDTH 2
`endif

module sbr_drain_walker #(
   parameter int unsigned MAX_ENTRIES = `MAX_SBR_ENTRIES
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           abort,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [`SBR_ID_WIDTH-1:0]       banks_drained,
   output logic                           sbr_find_max_en,
   input  logic [`SBR_ID_WIDTH-1:0]       sbr_max_addr,
   input  logic [`REQUEST_ID_WIDTH-1:0]   sbr_max_requests,
   output logic [`SBR_ID_WIDTH-1:0]       sbr_rd_addr,
   input  logic [`BANK_GROUP_WIDTH-1:0]   sbr_rd_bank_group,
   input  logic [`BANK_WIDTH-1:0]         sbr_rd_bank,
   input  logic [`SRR_ID_WIDTH-1:0]       sbr_rd_row_count,
   input  logic [`SRR_ID_WIDTH-1:0]       sbr_rd_head_srr,
   input  logic [`SRR_ID_WIDTH-1:0]       sbr_rd_tail_srr,
   output logic                           sbr_upd_en,
   output logic [`SBR_ID_WIDTH-1:0]       sbr_upd_addr,
   output logic [`REQUEST_ID_WIDTH-1:0]   sbr_upd_total_requests,
   output logic [`SRR_ID_WIDTH-1:0]       sbr_upd_row_count,
   output logic [`SRR_ID_WIDTH-1:0]       sbr_upd_tail_srr,
   output logic [`SRR_ID_WIDTH-1:0]       srr_rd_addr,
   input  logic [`ROW_WIDTH-1:0]          srr_rd_row,
   input  logic [`REQUEST_ID_WIDTH-1:0]   srr_rd_count,
   input  logic [`SRR_ID_WIDTH-1:0]       srr_rd_next,
   input  logic                           srr_rd_last,
   output logic                           iss_valid,
   input  logic                           iss_ready,
   output logic [`BANK_GROUP_WIDTH-1:0]   iss_bank_group,
   output logic [`BANK_WIDTH-1:0]         iss_bank,
   output logic [`ROW_WIDTH-1:0]          iss_row,
   output logic [`REQUEST_ID_WIDTH-1:0]   iss_count,
   output logic                           iss_last_of_bank
);

   localparam int unsigned SbrW = `SBR_ID_WIDTH;
   localparam int unsigned ReqW = `REQUEST_ID_WIDTH;
   localparam int unsigned SrrW = `SRR_ID_WIDTH;
   localparam int unsigned RowW = `ROW_WIDTH;
   localparam int unsigned BgW  = `BANK_GROUP_WIDTH;
   localparam int unsigned BkW  = `BANK_WIDTH;

   // The SBR index must be able to address every table entry.
   if (MAX_ENTRIES > (2 ** SbrW)) begin : g_size_check
      $error("sbr_drain_walker: SBR_ID_WIDTH too narrow for MAX_ENTRIES");
   end

   typedef enum logic [3:0] {
      StIdle, StFind, StSbrRd, StSbrCap, StSrrRd, StSrrCap, StIssue, StRetire, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [SbrW-1:0]   cur_sbr_q, cur_sbr_d;
   logic [BgW-1:0]    bg_q, bg_d;
   logic [BkW-1:0]    bank_q, bank_d;
   logic [SrrW-1:0]   tail_q, tail_d;
   logic [SrrW-1:0]   srr_addr_q, srr_addr_d;
   logic [RowW-1:0]   row_q, row_d;
   logic [ReqW-1:0]   cnt_q, cnt_d;
   logic [SrrW-1:0]   next_q, next_d;
   logic              last_q, last_d;
   logic [SbrW-1:0]   drained_q, drained_d;
`ifdef SBR_WALK_GUARD_EN
   logic [SrrW-1:0]   rows_left_q, rows_left_d;
   logic              err_q, err_d;
   logic              rows_end;
`else
   logic              unused_row_count;
   assign unused_row_count = ^sbr_rd_row_count;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cur_sbr_q   <= '0;
         bg_q        <= '0;
         bank_q      <= '0;
         tail_q      <= '0;
         srr_addr_q  <= '0;
         row_q       <= '0;
         cnt_q       <= '0;
         next_q      <= '0;
         last_q      <= 1'b0;
         drained_q   <= '0;
`ifdef SBR_WALK_GUARD_EN
         rows_left_q <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cur_sbr_q   <= cur_sbr_d;
         bg_q        <= bg_d;
         bank_q      <= bank_d;
         tail_q      <= tail_d;
         srr_addr_q  <= srr_addr_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         next_q      <= next_d;
         last_q      <= last_d;
         drained_q   <= drained_d;
`ifdef SBR_WALK_GUARD_EN
         rows_left_q <= rows_left_d;
         err_q       <= err_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_sbr_d  = cur_sbr_q;
      bg_d       = bg_q;
      bank_d     = bank_q;
      tail_d     = tail_q;
      srr_addr_d = srr_addr_q;
      row_d      = row_q;
      cnt_d      = cnt_q;
      next_d     = next_q;
      last_d     = last_q;
      drained_d  = drained_q;
`ifdef SBR_WALK_GUARD_EN
      rows_left_d = rows_left_q;
      err_d       = err_q;
      rows_end    = (rows_left_q == SrrW'(1));
`endif

      // Abort wins over everything, including a same-cycle handshake or retire.
      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d   = StFind;
                  drained_d = '0;
`ifdef SBR_WALK_GUARD_EN
                  err_d     = 1'b0;
`endif
               end
            end
            StFind: begin
               if (sbr_max_requests == '0) begin
                  state_d = StDone;
               end else begin
                  cur_sbr_d = sbr_max_addr;
                  state_d   = StSbrRd;
               end
            end
            StSbrRd: state_d = StSbrCap;
            StSbrCap: begin
               bg_d       = sbr_rd_bank_group;
               bank_d     = sbr_rd_bank;
               tail_d     = sbr_rd_tail_srr;
               srr_addr_d = sbr_rd_head_srr;
               state_d    = StSrrRd;
`ifdef SBR_WALK_GUARD_EN
               rows_left_d = sbr_rd_row_count;
               if (sbr_rd_row_count == '0) begin
                  // An empty bank cannot be walked; flag it and retire straight away.
                  err_d   = 1'b1;
                  state_d = StRetire;
               end
`endif
            end
            StSrrRd: state_d = StSrrCap;
            StSrrCap: begin
               row_d   = srr_rd_row;
               cnt_d   = srr_rd_count;
               next_d  = srr_rd_next;
               state_d = StIssue;
`ifdef SBR_WALK_GUARD_EN
               last_d = srr_rd_last | rows_end;
               if (srr_rd_last != rows_end) begin
                  err_d = 1'b1;
               end
`else
               last_d = srr_rd_last;
`endif
            end
            StIssue: begin
               if (iss_ready) begin
                  if (last_q) begin
                     state_d = StRetire;
                  end else begin
                     srr_addr_d = next_q;
                     state_d    = StSrrRd;
`ifdef SBR_WALK_GUARD_EN
                     rows_left_d = rows_left_q - SrrW'(1);
`endif
                  end
               end
            end
            StRetire: begin
               drained_d = drained_q + SbrW'(1);
               state_d   = StFind;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end

      busy                   = (state_q != StIdle);
      done                   = (state_q == StDone);
      sbr_find_max_en        = (state_q == StFind);
      sbr_upd_en             = (state_q == StRetire) && !abort;
      iss_valid              = (state_q == StIssue);
      banks_drained          = drained_q;
      sbr_rd_addr            = cur_sbr_q;
      sbr_upd_addr           = cur_sbr_q;
      sbr_upd_total_requests = '0;
      sbr_upd_row_count      = '0;
      sbr_upd_tail_srr       = tail_q;
      srr_rd_addr            = srr_addr_q;
      iss_bank_group         = bg_q;
      iss_bank               = bank_q;
      iss_row                = row_q;
      iss_count              = cnt_q;
      iss_last_of_bank       = last_q;
`ifdef SBR_WALK_GUARD_EN
      err                    = err_q;
`else
      err                    = 1'b0;
`endif
   end

endmodule
